// File: rtl/dot_product_4bit_pkg.sv
// Shared constants and helpers for the dot_product_4bit datapath and controller.
package dot_product_4bit_pkg;

  localparam int OPERAND_W = 4;
  localparam int PROD_W    = 8;

  // Controller state encoding.
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  // The accumulator must be at least PROD_W + ceil(log2(LEN)) bits wide.
  // The largest possible sum is LEN*225, which then always fits, so the
  // running sum can never wrap.
  function automatic bit acc_w_legal(input int len, input int acc_w);
    return acc_w >= PROD_W + $clog2(len);
  endfunction

endpackage

// File: rtl/Multiplier_4bit.sv
// Gate-level 4x4 unsigned array multiplier: AND partial products folded
// row by row through ripple-carry full-adder chains. Purely combinational.
module Multiplier_4bit
  import dot_product_4bit_pkg::*;
(
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  output logic [PROD_W-1:0]    p_o
);

  logic [OPERAND_W-1:0] pp [OPERAND_W];
  logic [OPERAND_W:0]   row_acc;
  logic [OPERAND_W-1:0] row_sum;
  logic                 carry;
  logic                 fa_x;
  logic                 fa_y;
  logic [PROD_W-1:0]    prod;

  // One row of partial products per bit of b_i.
  genvar gi;
  generate
    for (gi = 0; gi < OPERAND_W; gi++) begin : g_pp
      assign pp[gi] = a_i & {OPERAND_W{b_i[gi]}};
    end
  endgenerate

  // Fold each shifted partial-product row into the running row with a
  // full-adder chain; the low bit of every row is a finished product bit.
  always_comb begin
    prod    = '0;
    row_sum = '0;
    carry   = 1'b0;
    fa_x    = 1'b0;
    fa_y    = 1'b0;
    row_acc = {1'b0, pp[0]};
    prod[0] = row_acc[0];
    for (int i = 1; i < OPERAND_W; i++) begin
      carry = 1'b0;
      for (int j = 0; j < OPERAND_W; j++) begin
        fa_x       = pp[i][j];
        fa_y       = row_acc[j+1];
        row_sum[j] = fa_x ^ fa_y ^ carry;
        carry      = (fa_x & fa_y) | (carry & (fa_x ^ fa_y));
      end
      row_acc = {carry, row_sum};
      prod[i] = row_acc[0];
    end
    prod[PROD_W-1:OPERAND_W] = row_acc[OPERAND_W:1];
  end

  assign p_o = prod;

endmodule

// File: rtl/dot_product_4bit.sv
// Streaming dot product of 4-bit unsigned vectors: accepts operand pairs over
// valid/ready, accumulates their products and presents one registered result
// per vector over a second valid/ready handshake.
module dot_product_4bit
  import dot_product_4bit_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int CNT_W = 4,
  parameter int ACC_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W:0]       out_count
);

  generate
    if (!acc_w_legal(LEN, ACC_W)) begin : g_bad_acc_w
      $error("dot_product_4bit: ACC_W too narrow for LEN");
    end
    if (LEN < 1 || LEN > 16 || (1 << CNT_W) < LEN) begin : g_bad_len
      $error("dot_product_4bit: LEN/CNT_W out of range");
    end
  endgenerate

  logic [0:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W:0]    out_count_q, out_count_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;
  logic              vec_end;

  Multiplier_4bit u_mult (
    .a_i (in_a),
    .b_i (in_b),
    .p_o (prod)
  );

  // Handshake outputs come from state decode only; no in_* to out_* path.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

  // The first element of a vector starts from zero regardless of acc_q.
  assign acc_base = (cnt_q == '0) ? '0 : acc_q;
  assign acc_next = acc_base + ACC_W'(prod);
  assign vec_end  = in_last || (cnt_q == CNT_W'(LEN - 1));

  // Next-state logic: accumulate on accept, latch the result at vector end,
  // and return to accumulation once the sink takes the result.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          if (vec_end) begin
            out_sum_d   = acc_next;
            out_count_d = {1'b0, cnt_q} + (CNT_W + 1)'(1);
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_DONE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
